// File: rtl/i2s_serf.sv
// i2s_serf: I2S slave receiver that turns the RN52 serial stream into parallel left/right PCM
// samples. Everything runs on the system clock; I2S_sclk, I2S_ws and I2S_data are oversampled
// through 3-flop synchronizers, and all decisions happen only on a detected sclk rising edge.
//
// Ports:
//   clk        - system clock (50 MHz)
//   rst_n      - synchronous reset, active low
//   I2S_sclk   - I2S bit clock (asynchronous, sampled)
//   I2S_ws     - word select, 0 = left, 1 = right
//   I2S_data   - serial data, MSB first, changes on sclk falling edge
//   lft_chnnl  - left sample (two's complement), updated only with vld
//   rght_chnnl - right sample (two's complement), updated only with vld
//   vld        - one-clk pulse when a new left/right pair is presented
//
// Optional build macro I2S_SERF_ERR_EN adds:
//   frame_err  - one-clk pulse on each short-frame abort
//   err_cnt    - saturating count of short-frame aborts
module i2s_serf #(
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I2S_sclk,
    input  logic              I2S_ws,
    input  logic              I2S_data,
    output logic [DATA_W-1:0] lft_chnnl,
    output logic [DATA_W-1:0] rght_chnnl,
    output logic              vld
`ifdef I2S_SERF_ERR_EN
    ,
    output logic              frame_err,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [4:0] LastBit = 5'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLeft,
        StWaitR,
        StRight,
        StWaitL
    } state_e;

    state_e state_q, state_d;

    logic [2:0]        sclk_sync_q;
    logic [2:0]        ws_sync_q;
    logic [2:0]        data_sync_q;
    logic              ws_prev_q;
    logic [4:0]        bit_cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] lft_hold_q;
    logic [DATA_W-1:0] lft_q;
    logic [DATA_W-1:0] rght_q;
    logic              vld_q;

    logic              sclk_rise;
    logic              ws_s;
    logic              data_s;
    logic              ws_fall;
    logic              ws_rise;
    logic              ws_edge;
    logic              last_bit;
    logic [DATA_W-1:0] shreg_next;

    // Datapath controls produced by the FSM output process
    logic              clr_cnt;
    logic              shift_en;
    logic              load_left;
    logic              load_out;

    assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ws_s       = ws_sync_q[2];
    assign data_s     = data_sync_q[2];
    // ws_prev_q is the ws value seen on the previous sclk rise, so these are only
    // meaningful in cycles where sclk_rise is high.
    assign ws_fall    = ws_prev_q & ~ws_s;
    assign ws_rise    = ~ws_prev_q & ws_s;
    assign ws_edge    = ws_fall | ws_rise;
    assign last_bit   = (bit_cnt_q == LastBit);
    assign shreg_next = {shreg_q[DATA_W-2:0], data_s};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a ws edge inside a word (even on its final bit) aborts to idle.
    always_comb begin
        state_d = state_q;
        if (sclk_rise) begin
            case (state_q)
                StIdle:  if (ws_fall) state_d = StLeft;
                StLeft: begin
                    if (ws_edge)       state_d = StIdle;
                    else if (last_bit) state_d = StWaitR;
                end
                StWaitR: if (ws_rise) state_d = StRight;
                StRight: begin
                    if (ws_edge)       state_d = StIdle;
                    else if (last_bit) state_d = StWaitL;
                end
                StWaitL: if (ws_fall) state_d = StLeft;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output/control logic
    always_comb begin
        clr_cnt   = 1'b0;
        shift_en  = 1'b0;
        load_left = 1'b0;
        load_out  = 1'b0;
        if (sclk_rise) begin
            case (state_q)
                StIdle, StWaitL: clr_cnt = ws_fall;
                StWaitR:         clr_cnt = ws_rise;
                StLeft: begin
                    if (!ws_edge) begin
                        shift_en  = 1'b1;
                        load_left = last_bit;
                    end
                end
                StRight: begin
                    if (!ws_edge) begin
                        shift_en = 1'b1;
                        load_out = last_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchronizers and datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ws_sync_q   <= '0;
            data_sync_q <= '0;
            ws_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            lft_hold_q  <= '0;
            lft_q       <= '0;
            rght_q      <= '0;
            vld_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], I2S_sclk};
            ws_sync_q   <= {ws_sync_q[1:0], I2S_ws};
            data_sync_q <= {data_sync_q[1:0], I2S_data};
            if (sclk_rise) begin
                ws_prev_q <= ws_s;
            end
            if (clr_cnt) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            if (shift_en) begin
                shreg_q <= shreg_next;
            end
            if (load_left) begin
                lft_hold_q <= shreg_next;
            end
            if (load_out) begin
                lft_q  <= lft_hold_q;
                rght_q <= shreg_next;
            end
            vld_q <= load_out;
        end
    end

    assign lft_chnnl  = lft_q;
    assign rght_chnnl = rght_q;
    assign vld        = vld_q;

`ifdef I2S_SERF_ERR_EN
    logic       abort;
    logic       frame_err_q;
    logic [7:0] err_cnt_q;

    assign abort = sclk_rise & ws_edge & ((state_q == StLeft) | (state_q == StRight));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            frame_err_q <= abort;
            if (abort && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_serf.sv
`timescale 1ns/1ps
module tb_i2s_serf;

    localparam int DATA_W = 24;
    localparam int HALF   = 180;  // sclk half period in ns (~2.8 MHz)

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk  = 1'b1;
    logic              ws    = 1'b1;
    logic              sd    = 1'b0;
    logic [DATA_W-1:0] lft;
    logic [DATA_W-1:0] rght;
    logic              vld;
`ifdef I2S_SERF_ERR_EN
    logic              frame_err;
    logic [7:0]        err_cnt;
`endif

    i2s_serf #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .I2S_sclk   (sclk),
        .I2S_ws     (ws),
        .I2S_data   (sd),
        .lft_chnnl  (lft),
        .rght_chnnl (rght),
        .vld        (vld)
`ifdef I2S_SERF_ERR_EN
        ,
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
`endif
    );

    always #10 clk = ~clk;

    int                checks     = 0;
    int                errors     = 0;
    int                vld_cnt    = 0;
    int                err_pulses = 0;
    logic [DATA_W-1:0] exp_l      = '0;
    logic [DATA_W-1:0] exp_r      = '0;
    logic              vld_prev   = 1'b0;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        int                slot;
        int                nfr;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every vld pulse must carry the currently expected pair and be exactly one clk wide.
    always @(negedge clk) begin
        if (!rst_n) begin
            vld_prev <= 1'b0;
        end else begin
            if (vld) begin
                vld_cnt <= vld_cnt + 1;
                check("vld_lft", 32'(lft), 32'(exp_l));
                check("vld_rght", 32'(rght), 32'(exp_r));
                check("vld_width", 32'(vld_prev), 32'd0);
            end
            vld_prev <= vld;
`ifdef I2S_SERF_ERR_EN
            if (frame_err) err_pulses <= err_pulses + 1;
`endif
        end
    end

    // One sclk period: ws/data change on the falling edge, receiver samples on the rise.
    task automatic send_period(input logic w, input logic d);
        sclk = 1'b0;
        ws   = w;
        sd   = d;
        #HALF;
        sclk = 1'b1;
        #HALF;
    endtask

    // ws leads data by one period: the last period of a slot already shows the next ws.
    task automatic send_slot(input logic [DATA_W-1:0] word, input int slot,
                             input logic w, input logic w_next);
        for (int i = 0; i < slot; i++) begin
            send_period((i == slot - 1) ? w_next : w,
                        (i < DATA_W) ? word[DATA_W-1-i] : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                              input int slot);
        send_slot(l, slot, 1'b0, 1'b1);
        send_slot(r, slot, 1'b1, 1'b0);
    endtask

    // Brings the receiver from idle to the start of a left word.
    task automatic start_seq();
        send_period(1'b1, 1'b0);
        send_period(1'b1, 1'b0);
        send_period(1'b0, 1'b0);
    endtask

    initial begin
        int base;
        logic [11:0] partial;

        tbl[0] = '{l: 24'h800000, r: 24'h7FFFFF, slot: 32, nfr: 10};
        tbl[1] = '{l: 24'h13579B, r: 24'hECA864, slot: 32, nfr: 1};
        tbl[2] = '{l: 24'h13579B, r: 24'hECA864, slot: 25, nfr: 1};
        tbl[3] = '{l: 24'hFFFFFF, r: 24'h000001, slot: 25, nfr: 2};

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_lft", 32'(lft), 32'd0);
        check("rst_rght", 32'(rght), 32'd0);
        check("rst_vld", 32'(vld), 32'd0);

        // Startup in the middle of a right word, then a normal frame
        exp_l = 24'hA5F00F;
        exp_r = 24'h123456;
        fork
            begin
                for (int i = 0; i < 10; i++) send_period(1'b1, 1'(i % 2));
                send_period(1'b0, 1'b1);
                send_frame(24'hA5F00F, 24'h123456, 32);
            end
            begin
                #(4 * 2 * HALF);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        check("startup_vld_cnt", 32'(vld_cnt), 32'd1);
        check("startup_lft", 32'(lft), 32'h00A5F00F);
        check("startup_rght", 32'(rght), 32'h00123456);

        // Table: extremes, 64-sclk and 50-sclk frames
        for (int v = 0; v < 4; v++) begin
            exp_l = tbl[v].l;
            exp_r = tbl[v].r;
            base  = vld_cnt;
            for (int f = 0; f < tbl[v].nfr; f++) send_frame(tbl[v].l, tbl[v].r, tbl[v].slot);
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d_vld_cnt", v), 32'(vld_cnt - base), 32'(tbl[v].nfr));
            check($sformatf("vec%0d_lft", v), 32'(lft), 32'(tbl[v].l));
            check($sformatf("vec%0d_rght", v), 32'(rght), 32'(tbl[v].r));
        end

        // Short frame: ws rises after 12 left bits
        base    = vld_cnt;
        partial = 12'hABC;
        for (int i = 0; i < 12; i++) send_period(1'b0, partial[11-i]);
        send_period(1'b1, 1'b0);
        start_seq();
        repeat (10) @(negedge clk);
        check("short_vld_cnt", 32'(vld_cnt - base), 32'd0);
        check("short_lft_hold", 32'(lft), 32'h00FFFFFF);
        check("short_rght_hold", 32'(rght), 32'h00000001);
`ifdef I2S_SERF_ERR_EN
        check("short_err_pulses", 32'(err_pulses), 32'd1);
        check("short_err_cnt", 32'(err_cnt), 32'd1);
`endif
        exp_l = 24'h0F0F0F;
        exp_r = 24'hF0F0F0;
        base  = vld_cnt;
        send_frame(24'h0F0F0F, 24'hF0F0F0, 32);
        repeat (10) @(negedge clk);
        check("post_short_vld_cnt", 32'(vld_cnt - base), 32'd1);
        check("post_short_lft", 32'(lft), 32'h000F0F0F);
        check("post_short_rght", 32'(rght), 32'h00F0F0F0);

        // One-clk reset while in the right word
        base = vld_cnt;
        fork
            send_frame(24'h111111, 24'h222222, 32);
            begin
                #((32 + 8) * 2 * HALF);
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check("midrst_lft", 32'(lft), 32'd0);
                check("midrst_rght", 32'(rght), 32'd0);
                check("midrst_vld", 32'(vld), 32'd0);
            end
        join
        repeat (10) @(negedge clk);
        check("midrst_vld_cnt", 32'(vld_cnt - base), 32'd0);
        exp_l = 24'h3C3C3C;
        exp_r = 24'hC3C3C3;
        base  = vld_cnt;
        send_frame(24'h3C3C3C, 24'hC3C3C3, 32);
        repeat (10) @(negedge clk);
        check("post_rst_vld_cnt", 32'(vld_cnt - base), 32'd1);
        check("post_rst_lft", 32'(lft), 32'h003C3C3C);
        check("post_rst_rght", 32'(rght), 32'h00C3C3C3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
